// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle: five channels, with master and slave views.
interface axi_lite_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave terminating single-beat reads/writes into a bank of byte-strobed
// registers; register contents and per-register commit strobes drive the datapath.
module axi_lite_reg_cell #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   q,
    output logic                pulse
);
    // The strobe fires on every commit, even when no byte lane is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= we;
            if (we) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

module axi_lite_reg_slave #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axi_lite_if.slave                 s,
    output logic [REG_NUM*DATA_W-1:0] reg_o,
    output logic [REG_NUM-1:0]        wr_pulse_o
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbuf_t;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } rd_rsp_t;

    logic                             rdy_q;
    logic                             aw_full, w_full;
    logic [IDX_W-1:0]                 aw_idx;
    wbuf_t                            w_q;
    logic                             bvalid_q;
    logic [1:0]                       bresp_q;
    logic                             rvalid_q;
    rd_rsp_t                          r_q;
    logic [REG_NUM-1:0][DATA_W-1:0]   regs;
    logic [REG_NUM-1:0]               we;
    logic [DATA_W-1:0]                rd_data;
    logic [IDX_W-1:0]                 ar_idx;
    logic                             aw_in_range, ar_in_range;
    logic                             aw_hs, w_hs, ar_hs, commit;
    logic                             prot_unused;

    // rdy_q keeps every ready low while reset is held and for the reset edge itself.
    assign s.awready = rdy_q && !aw_full && !bvalid_q;
    assign s.wready  = rdy_q && !w_full  && !bvalid_q;
    assign s.arready = rdy_q && !rvalid_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = r_q.data;
    assign s.rresp   = r_q.resp;

    assign aw_hs  = s.awvalid && s.awready;
    assign w_hs   = s.wvalid  && s.wready;
    assign ar_hs  = s.arvalid && s.arready;
    assign commit = aw_full && w_full && !bvalid_q;

    assign ar_idx      = s.araddr[ADDR_W-1:2];
    assign aw_in_range = 32'(aw_idx) < REG_NUM;
    assign ar_in_range = 32'(ar_idx) < REG_NUM;

    assign prot_unused = ^{s.awprot, s.arprot, s.awaddr[1:0], s.araddr[1:0]};

    always_comb begin
        we = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            we[i] = commit && (aw_idx == IDX_W'(i));
        end
    end

    // Out-of-range indices match no register, so the mux yields zero for them.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (ar_idx == IDX_W'(i)) rd_data = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx   <= '0;
            w_q      <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            rdy_q <= 1'b1;
            if (bvalid_q && s.bready) begin
                bvalid_q <= 1'b0;
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_idx  <= s.awaddr[ADDR_W-1:2];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_q    <= '{data: s.wdata, strb: s.wstrb};
                end
                if (commit) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= aw_in_range ? OKAY : SLVERR;
                end
            end
        end
    end

    // Sampling regs here sees the pre-commit value when a write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            r_q      <= '0;
        end else if (rvalid_q && s.rready) begin
            rvalid_q <= 1'b0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            r_q      <= ar_in_range ? '{resp: OKAY, data: rd_data}
                                    : '{resp: SLVERR, data: '0};
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
        axi_lite_reg_cell #(.DATA_W(DATA_W)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we[g]),
            .wdata (w_q.data),
            .wstrb (w_q.strb),
            .q     (regs[g]),
            .pulse (wr_pulse_o[g])
        );
    end

    assign reg_o = regs;
endmodule
